// File: rtl/rv_dm_pkg.sv
// Shared types and constants for the RISC-V data-memory responder.
package rv_dm_pkg;

  // Access sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Default byte address of the console TX/status register
  localparam logic [31:0] CON_ADDR_DEFAULT = 32'h0010_0000;

  // Bit positions in the console status word
  localparam int unsigned STAT_FULL_BIT  = 0;
  localparam int unsigned STAT_EMPTY_BIT = 1;

  // Wait-state counter width (holds up to 16)
  localparam int unsigned WAIT_CNT_W = 5;

endpackage

// File: rtl/rv_console_fifo.sv
// Byte FIFO feeding the console sink; push while full is accepted only with a concurrent pop.
module rv_console_fifo #(
  parameter int unsigned g_DEPTH = 4,
  localparam int unsigned PTR_W  = $clog2(g_DEPTH),
  localparam int unsigned CNT_W  = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [7:0]       wdata,
  output logic [7:0]       rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [7:0]       buffer [g_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Qualify requests against occupancy
  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
  end

  // Storage, pointers (wrap naturally modulo depth) and occupancy count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(g_DEPTH); i++) buffer[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        buffer[wr_ptr] <= wdata;
        wr_ptr         <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  assign rdata = buffer[rd_ptr];
  assign full  = (count == CNT_W'(g_DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/rv_dm_responder.sv
// Data-memory responder for a small RISC-V core: word memory plus a memory-mapped console FIFO.
module rv_dm_responder
  import rv_dm_pkg::*;
#(
  parameter int unsigned g_MEM_WORDS    = 16384,
  parameter int unsigned g_WAIT_STATES  = 0,
  parameter logic [31:0] g_CONSOLE_ADDR = CON_ADDR_DEFAULT,
  parameter int unsigned g_FIFO_DEPTH   = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_data_s_i,
  input  logic [3:0]  dm_data_select_i,
  input  logic        dm_store_i,
  input  logic        dm_load_i,
  output logic [31:0] dm_data_l_o,
  output logic        dm_store_done_o,
  output logic        dm_load_done_o,
  output logic        dm_ready_o,
  output logic [7:0]  con_data_o,
  output logic        con_valid_o,
  input  logic        con_ready_i,
  output logic        err_o
);

  localparam int unsigned AW     = $clog2(g_MEM_WORDS);
  localparam int unsigned FCNT_W = $clog2(g_FIFO_DEPTH) + 1;

  logic [31:0] mem [g_MEM_WORDS];

  state_e                 state;
  state_e                 next_state;
  logic [31:0]            addr_q;
  logic [31:0]            data_q;
  logic [3:0]             sel_q;
  logic                   store_q;
  logic                   load_q;
  logic [WAIT_CNT_W-1:0]  wcnt;

  logic                   accept;
  logic [31:0]            op_addr;
  logic [31:0]            op_data;
  logic [3:0]             op_sel;
  logic                   op_store;
  logic                   op_load;
  logic                   is_con;
  logic [AW-1:0]          idx;
  logic                   wait_done;
  logic                   con_block;
  logic                   enter_done;
  logic [31:0]            status;

  logic                   fifo_push;
  logic                   fifo_pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [FCNT_W-1:0]      fifo_count;

  // Current operation: live inputs on the accepting cycle, latched copy afterwards
  always_comb begin
    accept    = dm_ready_o && (dm_load_i || dm_store_i);
    op_addr   = accept ? dm_addr_i        : addr_q;
    op_data   = accept ? dm_data_s_i      : data_q;
    op_sel    = accept ? dm_data_select_i : sel_q;
    op_store  = accept ? dm_store_i       : store_q;
    op_load   = accept ? (dm_load_i && !dm_store_i) : load_q;
    is_con    = (op_addr == g_CONSOLE_ADDR);
    idx       = op_addr[AW+1:2];
    wait_done = (wcnt >= WAIT_CNT_W'(g_WAIT_STATES));
    fifo_pop  = con_valid_o && con_ready_i;
    con_block = op_store && is_con && fifo_full && !fifo_pop;
    status                 = '0;
    status[STAT_FULL_BIT]  = fifo_full;
    status[STAT_EMPTY_BIT] = fifo_empty;
  end

  // Next-state decode
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (accept) next_state = ((g_WAIT_STATES != 0) || con_block) ? ST_WAIT : ST_DONE;
      ST_WAIT: if (wait_done && !con_block) next_state = ST_DONE;
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
    enter_done = (next_state == ST_DONE) && (state != ST_DONE);
    fifo_push  = enter_done && op_store && is_con;
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= ST_IDLE;
    else          state <= next_state;
  end

  // Request latch and wait-state counter
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      addr_q  <= '0;
      data_q  <= '0;
      sel_q   <= '0;
      store_q <= 1'b0;
      load_q  <= 1'b0;
      wcnt    <= '0;
    end else if (accept) begin
      addr_q  <= dm_addr_i;
      data_q  <= dm_data_s_i;
      sel_q   <= dm_data_select_i;
      store_q <= dm_store_i;
      load_q  <= dm_load_i && !dm_store_i;
      wcnt    <= WAIT_CNT_W'(1);
    end else if (state == ST_WAIT && !wait_done) begin
      wcnt <= wcnt + WAIT_CNT_W'(1);
    end
  end

  // Registered handshake outputs, load data and sticky error
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      dm_ready_o      <= 1'b1;
      dm_load_done_o  <= 1'b0;
      dm_store_done_o <= 1'b0;
      dm_data_l_o     <= '0;
      err_o           <= 1'b0;
    end else begin
      dm_ready_o      <= (next_state == ST_IDLE);
      dm_load_done_o  <= enter_done && op_load;
      dm_store_done_o <= enter_done && op_store;
      if (enter_done && op_load) dm_data_l_o <= is_con ? status : mem[idx];
      if (accept && dm_load_i && dm_store_i) err_o <= 1'b1;
    end
  end

  // Byte-lane memory write; contents survive reset
  always_ff @(posedge clk_i) begin
    if (enter_done && op_store && !is_con) begin
      for (int b = 0; b < 4; b++) begin
        if (op_sel[b]) mem[idx][8*b +: 8] <= op_data[8*b +: 8];
      end
    end
  end

  rv_console_fifo #(
    .g_DEPTH (g_FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_i),
    .rst_n (rst_n_i),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (op_data[7:0]),
    .rdata (con_data_o),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign con_valid_o = (fifo_count != '0);

endmodule

// File: tb/tb_rv_dm_responder.sv
// Directed bench for rv_dm_responder: behavioural model plus per-cycle compare on a zero-wait instance,
// hand-timed checks on a three-wait-state instance.
module tb_rv_dm_responder;

  localparam int unsigned MW  = 1024;
  localparam logic [31:0] CON = 32'h0010_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Zero-wait-state instance
  logic        rst0_n, st0, ld0, sd0, ldd0, rdy0, cv0, cr0, err0;
  logic [31:0] a0, d0, dl0;
  logic [3:0]  s0;
  logic [7:0]  cd0;

  // Three-wait-state instance
  logic        rst1_n, st1, ld1, sd1, ldd1, rdy1, cv1, err1;
  logic        cr1 = 1'b1;
  logic [31:0] a1, d1, dl1;
  logic [3:0]  s1;
  logic [7:0]  cd1;

  rv_dm_responder #(.g_MEM_WORDS(MW), .g_WAIT_STATES(0)) dut0 (
    .clk_i(clk), .rst_n_i(rst0_n), .dm_addr_i(a0), .dm_data_s_i(d0),
    .dm_data_select_i(s0), .dm_store_i(st0), .dm_load_i(ld0), .dm_data_l_o(dl0),
    .dm_store_done_o(sd0), .dm_load_done_o(ldd0), .dm_ready_o(rdy0),
    .con_data_o(cd0), .con_valid_o(cv0), .con_ready_i(cr0), .err_o(err0));

  rv_dm_responder #(.g_MEM_WORDS(MW), .g_WAIT_STATES(3)) dut1 (
    .clk_i(clk), .rst_n_i(rst1_n), .dm_addr_i(a1), .dm_data_s_i(d1),
    .dm_data_select_i(s1), .dm_store_i(st1), .dm_load_i(ld1), .dm_data_l_o(dl1),
    .dm_store_done_o(sd1), .dm_load_done_o(ldd1), .dm_ready_o(rdy1),
    .con_data_o(cd1), .con_valid_o(cv1), .con_ready_i(cr1), .err_o(err1));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model of the zero-wait instance
  logic [31:0] m_mem [MW];
  logic [7:0]  q[$];
  logic [7:0]  out_q[$];
  bit          m_err = 1'b0;
  int          ld_at = -1;
  int          st_at = -1;
  logic [31:0] exp_rd = '0;
  bit          skip = 1'b1;
  int          cyc = 0;
  logic [31:0] last_rd;
  logic        last_ld;

  always @(posedge clk) cyc <= cyc + 1;

  // Per-cycle compare of dut0 against the model
  always @(negedge clk) begin
    if (rst0_n && !skip) begin
      chk("load_done", 32'(ldd0), 32'(cyc == ld_at));
      if (cyc == ld_at) chk("load_data", dl0, exp_rd);
      chk("store_done", 32'(sd0), 32'(cyc == st_at));
      chk("ready", 32'(rdy0), 32'(!(cyc == ld_at || cyc == st_at)));
    end
    if (rst0_n) begin
      chk("err", 32'(err0), 32'(m_err));
      chk("con_valid", 32'(cv0), 32'(q.size() != 0));
      if (q.size() != 0) chk("con_data", 32'(cd0), 32'(q[0]));
      if (q.size() != 0 && cr0) begin
        out_q.push_back(cd0);
        void'(q.pop_front());
      end
    end
  end

  // Model effect of an accepted request (called just after the accepting edge)
  task automatic model_apply(input bit ld, input bit st, input logic [31:0] a,
                             input logic [31:0] d, input logic [3:0] sel);
    int w;
    w = int'((a >> 2) % MW);
    if (st) begin
      if (a == CON) q.push_back(d[7:0]);
      else for (int b = 0; b < 4; b++) if (sel[b]) m_mem[w][8*b +: 8] = d[8*b +: 8];
      st_at = cyc;
    end else if (ld) begin
      exp_rd = (a == CON) ? {30'b0, q.size() == 0, q.size() == 4} : m_mem[w];
      ld_at  = cyc;
    end
    if (ld && st) m_err = 1'b1;
  endtask

  // One request on dut0; returns the DONE-cycle load data and load_done
  task automatic access(input bit ld, input bit st, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] sel);
    int n = 0;
    @(negedge clk);
    while (!rdy0 && n < 50) begin @(negedge clk); n++; end
    if (!rdy0) begin
      checks++; errors++;
      $display("FAIL ready_timeout: got 0 expected 1");
    end
    a0 = a; d0 = d; s0 = sel; ld0 = ld; st0 = st;
    @(posedge clk); #1;
    ld0 = 1'b0; st0 = 1'b0;
    model_apply(ld, st, a, d, sel);
    @(negedge clk);
    last_rd = dl0;
    last_ld = ldd0;
  endtask

  // One request on dut1 with its 1+3 cycle latency checked cycle by cycle
  task automatic acc1(input bit ld, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd);
    @(negedge clk);
    a1 = a; d1 = d; s1 = 4'hF; ld1 = ld; st1 = !ld;
    @(posedge clk); #1;
    ld1 = 1'b0; st1 = 1'b0;
    rd = '0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk("w3_ready", 32'(rdy1), 32'(k == 5));
      chk("w3_done", 32'(ld ? ldd1 : sd1), 32'(k == 4));
      if (k == 4) rd = dl1;
    end
  endtask

  logic [31:0] rd1;
  int          bad;

  initial begin
    rst0_n = 1'b0; rst1_n = 1'b0;
    {st0, ld0, st1, ld1} = '0;
    a0 = '0; d0 = '0; s0 = '0; a1 = '0; d1 = '0; s1 = '0;
    cr0 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(rdy0), 32'd1);
    chk("rst_done", 32'({sd0, ldd0}), 32'd0);
    chk("rst_data", dl0, 32'd0);
    chk("rst_con", 32'({cv0, cd0}), 32'd0);
    chk("rst_err", 32'(err0), 32'd0);
    chk("rst_ready1", 32'(rdy1), 32'd1);
    rst0_n = 1'b1; rst1_n = 1'b1; skip = 1'b0;

    // Byte-lane merge and one-cycle latency
    access(0, 1, 32'h40, 32'h1122_3344, 4'hF);
    access(0, 1, 32'h40, 32'hDEAD_BEEF, 4'b0101);
    access(1, 0, 32'h40, 32'h0, 4'h0);
    chk("merge_data", last_rd, 32'h11AD_33EF);
    chk("merge_latency", 32'(last_ld), 32'd1);

    // Address wrap-around
    access(0, 1, 32'h40 + 4 * MW, 32'hCAFE_F00D, 4'hF);
    access(1, 0, 32'h40, 32'h0, 4'h0);
    chk("wrap_data", last_rd, 32'hCAFE_F00D);

    // Sub-word address bits ignored, partial lanes, top word via aliased address
    access(0, 1, 32'h44, 32'h0, 4'hF);
    access(0, 1, 32'h47, 32'hA1B2_C3D4, 4'b1010);
    access(1, 0, 32'h45, 32'h0, 4'h0);
    chk("lanes_data", last_rd, 32'hA100_C300);
    access(0, 1, 32'hFFC, 32'h0, 4'hF);
    access(0, 1, 32'hFFC, 32'h55AA_55AA, 4'b1000);
    access(1, 0, 32'h1FFC, 32'h0, 4'h0);
    chk("top_word", last_rd, 32'h5500_0000);

    // Console: fill, read status, stall the fifth store, release
    access(0, 1, 32'h0, 32'h0102_0304, 4'hF);
    access(1, 0, CON, 32'h0, 4'h0);
    chk("status_empty", last_rd, 32'h2);
    for (int i = 0; i < 4; i++) access(0, 1, CON, 32'h41 + 32'(i), 4'h1);
    access(1, 0, CON, 32'h0, 4'h0);
    chk("status_full", last_rd, 32'h1);
    skip = 1'b1;
    @(negedge clk);
    a0 = CON; d0 = 32'h45; s0 = 4'h1; st0 = 1'b1;
    @(posedge clk); #1;
    st0 = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("stall_ready", 32'(rdy0), 32'd0);
      chk("stall_no_done", 32'(sd0), 32'd0);
    end
    @(posedge clk); #1;
    cr0 = 1'b1;
    @(posedge clk); #1;
    q.push_back(8'h45);
    st_at = cyc;
    skip = 1'b0;
    repeat (10) @(negedge clk);
    chk("drain_count", 32'(out_q.size()), 32'd5);
    if (out_q.size() == 5)
      for (int i = 0; i < 5; i++) chk("drain_order", 32'(out_q[i]), 32'h41 + 32'(i));
    access(1, 0, 32'h0, 32'h0, 4'h0);
    chk("con_no_mem_write", last_rd, 32'h0102_0304);

    // Simultaneous load and store: store only, sticky error
    access(1, 1, 32'h80, 32'h7777_7777, 4'hF);
    access(1, 0, 32'h80, 32'h0, 4'h0);
    chk("both_store_data", last_rd, 32'h7777_7777);
    chk("err_sticky", 32'(err0), 32'd1);

    // Reset while a console store is stalled in WAIT
    @(posedge clk); #1;
    cr0 = 1'b0;
    for (int i = 0; i < 4; i++) access(0, 1, CON, 32'h57 + 32'(i), 4'h1);
    skip = 1'b1;
    @(negedge clk);
    a0 = CON; d0 = 32'h5A; s0 = 4'h1; st0 = 1'b1;
    @(posedge clk); #1;
    st0 = 1'b0;
    @(negedge clk);
    chk("pre_reset_wait", 32'(rdy0), 32'd0);
    rst0_n = 1'b0;
    q.delete(); m_err = 1'b0; ld_at = -1; st_at = -1;
    #1;
    chk("abort_ready", 32'(rdy0), 32'd1);
    chk("abort_con", 32'(cv0), 32'd0);
    chk("abort_err", 32'(err0), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst0_n = 1'b1; skip = 1'b0;
    repeat (4) @(negedge clk);
    access(1, 0, 32'h40, 32'h0, 4'h0);
    chk("mem_kept", last_rd, 32'hCAFE_F00D);

    // Three wait states: latency and reset abort
    acc1(0, 32'h8, 32'h1234_5678, rd1);
    acc1(1, 32'h8, 32'h0, rd1);
    chk("w3_load_data", rd1, 32'h1234_5678);
    @(negedge clk);
    a1 = 32'h8; ld1 = 1'b1;
    @(posedge clk); #1;
    ld1 = 1'b0;
    @(negedge clk);
    rst1_n = 1'b0;
    #1;
    chk("w3_abort_ready", 32'(rdy1), 32'd1);
    @(posedge clk); #1;
    rst1_n = 1'b1;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (ldd1 || !rdy1) bad++;
    end
    chk("w3_no_done_after_abort", 32'(bad), 32'd0);
    acc1(1, 32'h8, 32'h0, rd1);
    chk("w3_mem_kept", rd1, 32'h1234_5678);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "time limit");
  end

endmodule
